serial_to_parallel_stream: RTL and testbench
============================================

SERIAL_TO_PARALLEL_STREAM -- requirements
Module: serial_to_parallel_stream

Interface
REQ-001 The block SHALL have parameter width, default 8: output word width in bits.
REQ-002 The block SHALL have parameter in_width, default 1: bits per input beat; width mod in_width SHALL be 0, else elaboration fails.
REQ-003 The block SHALL have parameter msb_first, default 0: 0 = first beat lands in the LSBs, 1 = first beat lands in the MSBs.
REQ-004 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1: in_data/in_last are valid this cycle.
REQ-007 The block SHALL have port in_ready, output, 1: block accepts a beat this cycle.
REQ-008 The block SHALL have port in_data, input, in_width: beat payload.
REQ-009 The block SHALL have port in_last, input, 1: this beat ends the word early (flush partial word).
REQ-010 The block SHALL have port out_valid, output, 1: out_data/out_beats hold a complete word.
REQ-011 The block SHALL have port out_ready, input, 1: consumer takes the word this cycle.
REQ-012 The block SHALL have port out_data, output, width: assembled word.
REQ-013 The block SHALL have port out_beats, output, $clog2(N+1): number of filled beats in out_data, 1..N, where N = width/in_width.

Function
REQ-014 A beat SHALL be accepted when in_valid && in_ready.
REQ-015 in_ready SHALL equal !out_valid || out_ready: registered-output state only, with no combinational path from in_valid/in_last.
REQ-016 Beat k (0-based within the word) SHALL be written to slice [k*in_width +: in_width] when msb_first=0, and to [(N-1-k)*in_width +: in_width] when msb_first=1.
REQ-017 The beat counter SHALL increment per accepted beat and wrap to 0 when a word completes; gaps in in_valid SHALL not alter state.
REQ-018 A word SHALL complete on an accepted beat with counter == N-1 or in_last=1.
REQ-019 On completion, the next edge SHALL load out_data with the assembled word, load out_beats = counter+1, set out_valid, and clear the accumulator. Latency is one cycle from the final beat to out_valid.
REQ-020 Unfilled beat slices of a partial word SHALL read 0.
REQ-021 out_valid, out_data and out_beats SHALL hold stable while out_valid && !out_ready.
REQ-022 On out_valid && out_ready, the output register SHALL clear out_valid next edge unless a new word completes the same cycle, in which case the new word is loaded and out_valid stays 1. Full throughput SHALL be one beat per cycle with out_ready held high.
REQ-023 When N == 1, every accepted beat SHALL be a complete word with out_beats = 1.
REQ-024 in_last on beat N-1 SHALL behave identically to a normal full completion.

Reset
REQ-025 While rst=1: counter=0, accumulator=0, out_valid=0, out_data=0, out_beats=0, in_ready=1 on the following cycle.
REQ-026 Reset mid-word SHALL discard the partial word without emitting it.
REQ-027 Reset while out_valid=1 SHALL drop the pending word.

Structure
REQ-028 The msb_first encoding SHALL be a shared package enum (LSB_FIRST=0, MSB_FIRST=1) in serial_pkg, together with a function returning the slice base for (beat, N, mode). N and the counter width are module-local localparams.
REQ-029 The output holding register with its valid/ready logic SHALL be one sub-module, stream_out_reg, parametrised by payload width.

Verification
REQ-030 Bench SHALL cover: width=8, in_width=1, LSB-first, bits 1,0,1,1,0,0,1,0 -> out_data=8'h4D, out_beats=8, out_valid one cycle after the 8th beat.
REQ-031 Bench SHALL cover: width=8, in_width=2, MSB-first, beats 3,0,2,1 -> out_data=8'hC9, out_beats=4.
REQ-032 Bench SHALL cover: width=8, in_width=2, LSB-first, beats 3,1 with in_last on the 2nd -> out_data=8'h07, out_beats=2. MSB-first, same stimulus -> 8'hD0.
REQ-033 Bench SHALL cover backpressure: out_ready=0 while the first word is pending -> in_ready=0, out_data held. out_ready=1 with the next word's final beat presented -> back-to-back words, no beat lost.
REQ-034 Bench SHALL cover: rst pulsed after 3 of 8 beats, then 8 fresh beats 8'hA5 -> only 8'hA5 emitted, out_beats=8.
REQ-035 Bench SHALL cover: random in_valid gaps and random out_ready over 1000 words, checked against a reference model for data, out_beats and order.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: beat-ordering encoding and slice placement shared by the serial-to-parallel blocks
package serial_pkg;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } order_e;

  // Returns the slot index (in beats, not bits) that beat number `beat` occupies in an n-beat word
  function automatic int unsigned slice_base(input int unsigned beat, input int unsigned n,
                                             input order_e mode);
    return (mode == MSB_FIRST) ? n - 1 - beat : beat;
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// stream_out_reg: one-deep registered output stage with valid/ready handshake
module stream_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         free_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // load_i is only raised while free_o is high, so a load never overwrites an untaken word
  always_comb begin
    valid_d = load_i ? 1'b1 : valid_q && !ready_i;
    data_d  = load_i ? data_i : data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/serial_to_parallel_stream.sv
// serial_to_parallel_stream: packs in_width-bit beats into width-bit words with early flush on in_last
module serial_to_parallel_stream
  import serial_pkg::*;
#(
  parameter int width     = 8,
  parameter int in_width  = 1,
  parameter bit msb_first = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [in_width-1:0]                  in_data,
  input  logic                                 in_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [width-1:0]                     out_data,
  output logic [$clog2(width/in_width+1)-1:0]  out_beats
);

  localparam int N = width / in_width;
  localparam int BW = $clog2(N + 1);
  localparam order_e MODE = msb_first ? MSB_FIRST : LSB_FIRST;

  if (width % in_width != 0) begin : g_bad_width
    $error("serial_to_parallel_stream: width must be a multiple of in_width");
  end

  logic [BW-1:0]       cnt_q, cnt_d;
  logic [width-1:0]    acc_q, acc_d, word;
  logic                accept, done;
  logic [width+BW-1:0] pay_o;

  // word merges the current beat into the accumulator so a completing beat is never lost
  always_comb begin
    accept = in_valid && in_ready;
    done   = accept && (in_last || cnt_q == BW'(N - 1));
    word   = acc_q | (width'(in_data) << (in_width * slice_base(32'(cnt_q), N, MODE)));
    cnt_d  = done ? '0 : accept ? cnt_q + BW'(1) : cnt_q;
    acc_d  = done ? '0 : accept ? word : acc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  stream_out_reg #(.W(width + BW)) u_out (
    .clk     (clk),
    .rst     (rst),
    .load_i  (done),
    .data_i  ({word, cnt_q + BW'(1)}),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  (pay_o),
    .free_o  (in_ready)
  );

  assign {out_data, out_beats} = pay_o;

endmodule

// File: tb/tb_serial_to_parallel_stream.sv
// tb_serial_to_parallel_stream: directed and random checks of four parameterisations against a scoreboard
module tb_serial_to_parallel_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv [4];
  logic       il [4];
  logic [7:0] idat [4];
  logic       ory_dir [4];
  logic       ory [4];
  wire        iry [4];
  wire        ov [4];
  wire  [7:0] od [4];
  wire  [3:0] ob0;
  wire  [2:0] ob1, ob2;
  wire        ob3;
  wire  [3:0] obx [4];
  logic       rnd = 1'b0;
  logic       rnd_r = 1'b1;
  int         checks = 0, errors = 0, stalls = 0;
  logic [11:0] sb [4][$];
  logic [11:0] mon_e;
  int          len;

  assign obx[0] = ob0;
  assign obx[1] = {1'b0, ob1};
  assign obx[2] = {1'b0, ob2};
  assign obx[3] = {3'd0, ob3};

  always_comb begin
    for (int k = 0; k < 4; k++) ory[k] = ory_dir[k];
    if (rnd) ory[0] = rnd_r;
  end

  always @(posedge clk) begin
    #1;
    rnd_r = ($urandom_range(0, 3) != 0);
  end

  // a: 8/1 LSB-first, b: 8/2 MSB-first, c: 8/2 LSB-first, e: 8/8 (one beat per word)
  serial_to_parallel_stream #(.width(8), .in_width(1), .msb_first(1'b0)) u_a (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(iry[0]), .in_data(idat[0][0:0]),
    .in_last(il[0]), .out_valid(ov[0]), .out_ready(ory[0]), .out_data(od[0]), .out_beats(ob0));
  serial_to_parallel_stream #(.width(8), .in_width(2), .msb_first(1'b1)) u_b (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(iry[1]), .in_data(idat[1][1:0]),
    .in_last(il[1]), .out_valid(ov[1]), .out_ready(ory[1]), .out_data(od[1]), .out_beats(ob1));
  serial_to_parallel_stream #(.width(8), .in_width(2), .msb_first(1'b0)) u_c (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(iry[2]), .in_data(idat[2][1:0]),
    .in_last(il[2]), .out_valid(ov[2]), .out_ready(ory[2]), .out_data(od[2]), .out_beats(ob2));
  serial_to_parallel_stream #(.width(8), .in_width(8), .msb_first(1'b0)) u_e (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(iry[3]), .in_data(idat[3]),
    .in_last(il[3]), .out_valid(ov[3]), .out_ready(ory[3]), .out_data(od[3]), .out_beats(ob3));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst && ov[k] && ory[k]) begin
        checks++;
        assert (sb[k].size() != 0) else begin
          errors++;
          $error("FAIL sb%0d_unexpected: observed %0h/%0d expected no word", k, od[k], obx[k]);
        end
        if (sb[k].size() != 0) begin
          mon_e = sb[k].pop_front();
          checks++;
          assert ({obx[k], od[k]} === mon_e) else begin
            errors++;
            $error("FAIL sb%0d_word: observed beats=%0d data=%0h expected beats=%0d data=%0h",
                   k, obx[k], od[k], mon_e[11:8], mon_e[7:0]);
          end
        end
      end
    end
  end

  task automatic idle(int g);
    repeat (g) @(posedge clk);
    #1;
  endtask

  // Presents one beat and returns #1 after the edge that accepted it
  task automatic beat(int k, logic [7:0] d, bit last);
    int n = 0;
    iv[k] = 1'b1;
    idat[k] = d;
    il[k] = last;
    @(negedge clk);
    while (!iry[k] && n < 1000) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    if (n >= 1000) chk($sformatf("accept_timeout%0d", k), iry[k], 1);
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
    il[k] = 1'b0;
  endtask

  task automatic send_a(logic [7:0] w, int n, bit last_full, bit gaps);
    logic [7:0] m;
    m = w & 8'((9'd1 << n) - 9'd1);
    sb[0].push_back({4'(n), m});
    for (int i = 0; i < n; i++) begin
      beat(0, {7'd0, w[i]}, (i == n - 1) && (n < 8 || last_full));
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      iv[k] = 1'b0;
      il[k] = 1'b0;
      idat[k] = 8'd0;
      ory_dir[k] = 1'b1;
    end
    idle(3);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_valid%0d", k), ov[k], 0);
      chk($sformatf("rst_ready%0d", k), iry[k], 1);
      chk($sformatf("rst_data%0d", k), od[k], 0);
      chk($sformatf("rst_beats%0d", k), obx[k], 0);
    end

    // LSB-first serial bits 1,0,1,1,0,0,1,0
    sb[0].push_back({4'd8, 8'h4D});
    for (int i = 0; i < 8; i++) begin
      beat(0, {7'd0, 8'h4D >> i} & 8'h01, 1'b0);
      if (i == 6) chk("a_valid_early", ov[0], 0);
    end
    chk("a_valid_latency", ov[0], 1);
    chk("a_data_4d", od[0], 8'h4D);
    chk("a_beats_8", obx[0], 8);

    sb[1].push_back({4'd4, 8'hC9});
    beat(1, 8'd3, 1'b0);
    beat(1, 8'd0, 1'b0);
    beat(1, 8'd2, 1'b0);
    beat(1, 8'd1, 1'b0);
    chk("b_data_c9", od[1], 8'hC9);
    chk("b_beats_4", obx[1], 4);

    sb[2].push_back({4'd2, 8'h07});
    beat(2, 8'd3, 1'b0);
    beat(2, 8'd1, 1'b1);
    chk("c_data_07", od[2], 8'h07);
    chk("c_beats_2", obx[2], 2);
    sb[1].push_back({4'd2, 8'hD0});
    beat(1, 8'd3, 1'b0);
    beat(1, 8'd1, 1'b1);
    chk("b_data_d0", od[1], 8'hD0);
    chk("b_beats_2", obx[1], 2);

    // one-beat words stream with out_valid held high throughout
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      sb[3].push_back({4'd1, 8'(8'h30 + i)});
      beat(3, 8'(8'h30 + i), i[0]);
      chk("e_valid_stream", ov[3], 1);
      chk("e_beats_1", obx[3], 1);
    end
    chk("e_stalls", stalls, 0);

    // backpressure on the bit-serial instance: word held, beats refused
    ory_dir[0] = 1'b0;
    send_a(8'h3C, 8, 1'b0, 1'b0);
    iv[0] = 1'b1;
    idat[0] = 8'd1;
    idle(3);
    chk("a_hold_ready", iry[0], 0);
    chk("a_hold_valid", ov[0], 1);
    chk("a_hold_data", od[0], 8'h3C);
    chk("a_hold_beats", obx[0], 8);
    iv[0] = 1'b0;
    ory_dir[0] = 1'b1;

    // backpressure then release with the next word's final beat presented
    ory_dir[3] = 1'b0;
    sb[3].push_back({4'd1, 8'h11});
    beat(3, 8'h11, 1'b0);
    iv[3] = 1'b1;
    idat[3] = 8'h22;
    idle(2);
    chk("e_hold_ready", iry[3], 0);
    chk("e_hold_data", od[3], 8'h11);
    sb[3].push_back({4'd1, 8'h22});
    ory_dir[3] = 1'b1;
    beat(3, 8'h22, 1'b0);
    chk("e_b2b_valid", ov[3], 1);
    chk("e_b2b_data", od[3], 8'h22);
    idle(2);

    // reset while a word is pending drops it
    ory_dir[2] = 1'b0;
    beat(2, 8'd2, 1'b1);
    chk("c_pending_valid", ov[2], 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("c_rst_valid", ov[2], 0);
    chk("c_rst_data", od[2], 0);
    chk("c_rst_beats", obx[2], 0);
    chk("c_rst_ready", iry[2], 1);
    ory_dir[2] = 1'b1;

    // reset mid-word discards the partial accumulation
    beat(0, 8'd1, 1'b0);
    beat(0, 8'd1, 1'b0);
    beat(0, 8'd1, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("a_midrst_valid", ov[0], 0);
    send_a(8'hA5, 8, 1'b0, 1'b0);
    chk("a_a5_data", od[0], 8'hA5);
    chk("a_a5_beats", obx[0], 8);

    // full throughput, including in_last on the final beat of a full word
    stalls = 0;
    send_a(8'h5A, 8, 1'b0, 1'b0);
    send_a(8'hE7, 8, 1'b1, 1'b0);
    chk("a_throughput_stalls", stalls, 0);
    chk("a_last_full_beats", obx[0], 8);

    rnd = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      len = $urandom_range(1, 8);
      send_a(8'($urandom), len, 1'($urandom_range(0, 1)), 1'b1);
    end
    rnd = 1'b0;

    for (int n = 0; n < 200 && (sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0; n++)
      @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("drain%0d", k), sb[k].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
